keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad (column-drive, row-sense) and is the input-side counterpart of the multiplexed seven-segment display scan. It debounces one key at a time and emits single-cycle key events. It also keeps an 8-digit BCD entry buffer, `entry_o`, laid out exactly like the 32-bit word the display consumes, so PIN and amount entry can go straight to the display.

---
 rtl/keypad_pkg.sv | 74 +++++++
 rtl/keypad_entry_buf.sv | 66 ++++++
 rtl/keypad_scanner.sv | 138 +++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, frame classification types and the row/column key map.
package keypad_pkg;

   localparam logic [3:0] KEY_0    = 4'h0;
   localparam logic [3:0] KEY_1    = 4'h1;
   localparam logic [3:0] KEY_2    = 4'h2;
   localparam logic [3:0] KEY_3    = 4'h3;
   localparam logic [3:0] KEY_4    = 4'h4;
   localparam logic [3:0] KEY_5    = 4'h5;
   localparam logic [3:0] KEY_6    = 4'h6;
   localparam logic [3:0] KEY_7    = 4'h7;
   localparam logic [3:0] KEY_8    = 4'h8;
   localparam logic [3:0] KEY_9    = 4'h9;
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   localparam int unsigned ENTRY_DIGITS = 8;

   typedef enum logic [1:0] {ClsNone, ClsKey, ClsMulti} cls_kind_e;

   // idx is kept at zero for NONE and MULTI so whole-struct compares are exact.
   typedef struct packed {
      cls_kind_e  kind;
      logic [3:0] idx;   // 4*col + row
   } key_cls_t;

   localparam key_cls_t CLS_NONE = '{kind: ClsNone, idx: 4'h0};

   // Physical position to key code.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = KEY_0;
      unique case (row)
         2'd0: code = (col == 2'd3) ? KEY_A : 4'd1 + {2'b00, col};
         2'd1: code = (col == 2'd3) ? KEY_B : 4'd4 + {2'b00, col};
         2'd2: code = (col == 2'd3) ? KEY_C : 4'd7 + {2'b00, col};
         2'd3: begin
            unique case (col)
               2'd0: code = KEY_STAR;
               2'd1: code = KEY_0;
               2'd2: code = KEY_HASH;
               2'd3: code = KEY_D;
            endcase
         end
      endcase
      return code;
   endfunction

   // Zero bits -> NONE, one bit -> KEY(index), more -> MULTI.
   function automatic key_cls_t classify(input logic [15:0] frame);
      key_cls_t   cls;
      logic [4:0] ones;
      cls  = CLS_NONE;
      ones = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame[i]) begin
            ones    = ones + 5'd1;
            cls.idx = 4'(i);
         end
      end
      if (ones == 5'd1) begin
         cls.kind = ClsKey;
      end else if (ones > 5'd1) begin
         cls.kind = ClsMulti;
         cls.idx  = 4'h0;
      end
      return cls;
   endfunction

endpackage

// File: rtl/keypad_entry_buf.sv
// Eight-digit BCD entry buffer driven by accepted key events.
module keypad_entry_buf
   import keypad_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [31:0] entry,
   output logic [3:0]  digit_cnt,
   output logic        entry_done
);

   logic [31:0] entry_q, entry_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   // Decode the accepted key into a buffer edit.
   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (key_valid) begin
         if (key_code <= KEY_9) begin
            // A full buffer silently drops further digits.
            if (cnt_q < 4'(ENTRY_DIGITS)) begin
               entry_d = {entry_q[27:0], key_code};
               cnt_d   = cnt_q + 4'd1;
            end
         end else begin
            case (key_code)
               KEY_HASH: begin
                  if (cnt_q != 4'd0) begin
                     entry_d = entry_q >> 4;
                     cnt_d   = cnt_q - 4'd1;
                  end
               end
               KEY_STAR: begin
                  entry_d = 32'h0;
                  cnt_d   = 4'd0;
               end
               KEY_D:   done_d = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Buffer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= 32'h0;
         cnt_q   <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign entry      = entry_q;
   assign digit_cnt  = cnt_q;
   assign entry_done = done_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with frame debounce and a BCD entry buffer.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_TICKS      = 100000,
   parameter int unsigned DEBOUNCE_FRAMES = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row_i,
   output logic [3:0]  col_o,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic        key_held,
   output logic [31:0] entry_o,
   output logic [3:0]  digit_cnt,
   output logic        entry_done
);

   localparam int unsigned TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [3:0]        row_meta_q, row_sync_q;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [1:0]        col_q, col_d;
   logic [15:0]       snap_q, snap_d;
   logic              frame_ready_q, frame_ready_d;
   key_cls_t          frame_cls;
   key_cls_t          prev_q, prev_d;
   key_cls_t          stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [3:0]        code_q, code_d;

   // Two-flop synchroniser; idle rows read high (no key).
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= row_i;
         row_sync_q <= row_meta_q;
      end
   end

   // Column timing; rows are captured on the last tick of each column to allow settling.
   always_comb begin
      tick_d        = tick_q + TICK_ONE;
      col_d         = col_q;
      snap_d        = snap_q;
      frame_ready_d = 1'b0;
      if (tick_q == TICK_LAST) begin
         tick_d = '0;
         col_d  = col_q + 2'd1;
         unique case (col_q)
            2'd0: snap_d[3:0]   = ~row_sync_q;
            2'd1: snap_d[7:4]   = ~row_sync_q;
            2'd2: snap_d[11:8]  = ~row_sync_q;
            2'd3: snap_d[15:12] = ~row_sync_q;
         endcase
         frame_ready_d = (col_q == 2'd3);
      end
   end

   // Debounce on whole frames; MULTI frames only reset progress.
   always_comb begin
      frame_cls = classify(snap_q);
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      stable_d  = stable_q;
      valid_d   = 1'b0;
      code_d    = code_q;
      if (frame_ready_q) begin
         prev_d = frame_cls;
         if (frame_cls.kind == ClsMulti) begin
            cnt_d = '0;
         end else begin
            if (frame_cls == prev_q) begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = CNT_ONE;
            end
            if (cnt_d == CNT_MAX && frame_cls != stable_q) begin
               stable_d = frame_cls;
               if (frame_cls.kind == ClsKey) begin
                  valid_d = 1'b1;
                  code_d  = key_map(frame_cls.idx[1:0], frame_cls.idx[3:2]);
               end
            end
         end
      end
   end

   // Scan and debounce state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q        <= '0;
         col_q         <= 2'd0;
         snap_q        <= 16'h0;
         frame_ready_q <= 1'b0;
         prev_q        <= CLS_NONE;
         cnt_q         <= '0;
         stable_q      <= CLS_NONE;
         valid_q       <= 1'b0;
         code_q        <= 4'h0;
      end else begin
         tick_q        <= tick_d;
         col_q         <= col_d;
         snap_q        <= snap_d;
         frame_ready_q <= frame_ready_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         valid_q       <= valid_d;
         code_q        <= code_d;
      end
   end

   assign col_o     = ~(4'b0001 << col_q);
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_held  = (stable_q.kind != ClsNone);

   keypad_entry_buf u_entry_buf (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (valid_q),
      .key_code   (code_q),
      .entry      (entry_o),
      .digit_cnt  (digit_cnt),
      .entry_done (entry_done)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_i;
   logic [3:0]  col_o;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_held;
   logic [31:0] entry_o;
   logic [3:0]  digit_cnt;
   logic        entry_done;

   logic [15:0] pressed = 16'h0;   // bit 4*col+row

   int n_cmp = 0;
   int n_err = 0;

   // Event statistics gathered while stepping the clock.
   int         n_valid, n_done, n_done_follow, n_rise, n_held_cycles;
   logic [3:0] last_code;
   logic       prev_valid, prev_held;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_FRAMES(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .row_i      (row_i),
      .col_o      (col_o),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_held   (key_held),
      .entry_o    (entry_o),
      .digit_cnt  (digit_cnt),
      .entry_done (entry_done)
   );

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_i = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (!col_o[c]) begin
            for (int r = 0; r < 4; r++) begin
               if (pressed[4*c+r]) row_i[r] = 1'b0;
            end
         end
      end
   end

   task automatic clear_stats();
      n_valid = 0; n_done = 0; n_done_follow = 0; n_rise = 0; n_held_cycles = 0;
      last_code = 4'h0; prev_valid = key_valid; prev_held = key_held;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (key_valid) begin
            n_valid++;
            last_code = key_code;
            if (key_held && !prev_held) n_rise++;
         end
         if (entry_done) begin
            n_done++;
            if (prev_valid) n_done_follow++;
         end
         if (key_held) n_held_cycles++;
         prev_valid = key_valid;
         prev_held  = key_held;
      end
   endtask

   // Hold one key for 6 frames, then release for 5 frames.
   task automatic press(input int idx);
      pressed = 16'h0001 << idx;
      run(96);
      pressed = 16'h0;
      run(80);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pressed = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (col_o !== 4'b1110) begin n_err++; $display("FAIL rst_col: got %b want 1110", col_o); end
      n_cmp++; if ({key_valid, key_held, entry_done} !== 3'b000) begin
         n_err++; $display("FAIL rst_flags: got %b want 000", {key_valid, key_held, entry_done}); end
      n_cmp++; if ({key_code, entry_o, digit_cnt} !== 40'h0) begin
         n_err++; $display("FAIL rst_data: got %h want 0", {key_code, entry_o, digit_cnt}); end
      rst = 1'b0;
      clear_stats();
   endtask

   task automatic test_single_press();
      clear_stats();
      pressed = 16'h0001 << 5;   // key 5
      run(96);
      n_cmp++; if (n_valid !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", n_valid); end
      n_cmp++; if (last_code !== 4'h5) begin n_err++; $display("FAIL single_code: got %h want 5", last_code); end
      n_cmp++; if (n_rise !== 1) begin n_err++; $display("FAIL single_held_rise: got %0d want 1", n_rise); end
      n_cmp++; if (entry_o !== 32'h5) begin n_err++; $display("FAIL single_entry: got %h want 00000005", entry_o); end
      n_cmp++; if (digit_cnt !== 4'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", digit_cnt); end
      pressed = 16'h0;
      run(16);
      n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL release_early_held: got %b want 1", key_held); end
      run(64);
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL release_held: got %b want 0", key_held); end
      n_cmp++; if (n_valid !== 1) begin n_err++; $display("FAIL release_event: got %0d want 1", n_valid); end
   endtask

   task automatic test_bounce();
      clear_stats();
      for (int i = 0; i < 8; i++) begin
         pressed = (i % 2 == 0) ? (16'h0001 << 5) : 16'h0;
         run(16);
      end
      pressed = 16'h0;
      run(64);
      n_cmp++; if (n_valid !== 0) begin n_err++; $display("FAIL bounce_events: got %0d want 0", n_valid); end
      n_cmp++; if (n_held_cycles !== 0) begin n_err++; $display("FAIL bounce_held: got %0d want 0", n_held_cycles); end
   endtask

   task automatic test_multi();
      clear_stats();
      pressed = 16'h0011;        // keys 1 and 2
      run(96);
      n_cmp++; if (n_valid !== 0) begin n_err++; $display("FAIL multi_events: got %0d want 0", n_valid); end
      n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL multi_held: got %b want 0", key_held); end
      pressed = 16'h0001;        // release 2, keep 1
      run(96);
      n_cmp++; if (n_valid !== 1) begin n_err++; $display("FAIL multi_after_count: got %0d want 1", n_valid); end
      n_cmp++; if (last_code !== 4'h1) begin n_err++; $display("FAIL multi_after_code: got %h want 1", last_code); end
      pressed = 16'h0;
      run(80);
      n_cmp++; if (entry_o !== 32'h51) begin n_err++; $display("FAIL multi_entry: got %h want 00000051", entry_o); end
      n_cmp++; if (digit_cnt !== 4'd2) begin n_err++; $display("FAIL multi_cnt: got %0d want 2", digit_cnt); end
   endtask

   task automatic test_entry();
      int digit_idx[9] = '{0, 4, 8, 1, 5, 9, 2, 6, 10};   // keys 1..9
      press(3);                  // *
      n_cmp++; if ({entry_o, digit_cnt} !== 36'h0) begin
         n_err++; $display("FAIL entry_star_first: got %h want 0", {entry_o, digit_cnt}); end
      clear_stats();
      for (int i = 0; i < 9; i++) press(digit_idx[i]);
      n_cmp++; if (n_valid !== 9) begin n_err++; $display("FAIL entry_events: got %0d want 9", n_valid); end
      n_cmp++; if (entry_o !== 32'h12345678) begin n_err++; $display("FAIL entry_full: got %h want 12345678", entry_o); end
      n_cmp++; if (digit_cnt !== 4'd8) begin n_err++; $display("FAIL entry_full_cnt: got %0d want 8", digit_cnt); end
      press(11);                 // #
      n_cmp++; if (entry_o !== 32'h01234567) begin n_err++; $display("FAIL entry_bs: got %h want 01234567", entry_o); end
      n_cmp++; if (digit_cnt !== 4'd7) begin n_err++; $display("FAIL entry_bs_cnt: got %0d want 7", digit_cnt); end
      press(3);                  // *
      n_cmp++; if ({entry_o, digit_cnt} !== 36'h0) begin
         n_err++; $display("FAIL entry_clear: got %h want 0", {entry_o, digit_cnt}); end
      press(11);                 // # on empty buffer
      n_cmp++; if ({entry_o, digit_cnt} !== 36'h0) begin
         n_err++; $display("FAIL entry_bs_empty: got %h want 0", {entry_o, digit_cnt}); end
   endtask

   task automatic test_done();
      press(1);                  // 4
      clear_stats();
      press(15);                 // D
      n_cmp++; if (last_code !== 4'hD) begin n_err++; $display("FAIL done_code: got %h want d", last_code); end
      n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL done_pulses: got %0d want 1", n_done); end
      n_cmp++; if (n_done_follow !== 1) begin n_err++; $display("FAIL done_timing: got %0d want 1", n_done_follow); end
      n_cmp++; if ({entry_o, digit_cnt} !== 36'h4_1) begin
         n_err++; $display("FAIL done_entry: got %h want 000000041", {entry_o, digit_cnt}); end
      clear_stats();
      press(12);                 // A
      n_cmp++; if (n_valid !== 1 || last_code !== 4'hA) begin
         n_err++; $display("FAIL a_event: got %0d/%h want 1/a", n_valid, last_code); end
      n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL a_done: got %0d want 0", n_done); end
      n_cmp++; if ({entry_o, digit_cnt} !== 36'h4_1) begin
         n_err++; $display("FAIL a_entry: got %h want 000000041", {entry_o, digit_cnt}); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit found;
      clear_stats();
      pressed = 16'h0001 << 2;   // key 7
      run(32);
      n_cmp++; if (n_valid !== 0) begin n_err++; $display("FAIL mid_early: got %0d want 0", n_valid); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (col_o !== 4'b1110) begin n_err++; $display("FAIL mid_rst_col: got %b want 1110", col_o); end
      n_cmp++; if ({key_valid, key_held, entry_done, key_code, entry_o, digit_cnt} !== 43'h0) begin
         n_err++;
         $display("FAIL mid_rst_outs: got %h want 0",
                  {key_valid, key_held, entry_done, key_code, entry_o, digit_cnt});
      end
      lat = 0;
      found = 1'b0;
      while (!found && lat < 120) begin
         @(posedge clk);
         #1;
         lat++;
         if (key_valid) found = 1'b1;
      end
      n_cmp++; if (!found) begin n_err++; $display("FAIL mid_timeout: got none want key_valid"); end
      n_cmp++; if (found && (lat < 48 || lat > 51)) begin
         n_err++; $display("FAIL mid_latency: got %0d want 48..51", lat); end
      n_cmp++; if (key_code !== 4'h7) begin n_err++; $display("FAIL mid_code: got %h want 7", key_code); end
      pressed = 16'h0;
      run(80);
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_multi();
      test_entry();
      test_done();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
